// File: rtl/sdram_wb_bridge.sv
// Wishbone slave to SDRAM ping-pong FIFO bridge: writes fill write-ppfifo halves, reads drain read-ppfifo blocks.
// Optional FIFO-wait timeout is enabled by defining SDRAM_WB_BRIDGE_TIMEOUT_EN.
module sdram_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wbs_cyc,
  input  logic        i_wbs_stb,
  input  logic        i_wbs_we,
  input  logic [3:0]  i_wbs_sel,
  input  logic [31:0] i_wbs_adr,
  input  logic [31:0] i_wbs_dat,
  output logic [31:0] o_wbs_dat,
  output logic        o_wbs_ack,
  input  logic        sdram_ready,
  output logic        sdram_write_enable,
  output logic        sdram_read_enable,
  output logic [21:0] app_address,
  input  logic [1:0]  if_write_ready,
  input  logic [23:0] if_write_fifo_size,
  output logic [1:0]  if_write_activate,
  output logic        if_write_strobe,
  output logic [31:0] if_write_data,
  output logic [3:0]  if_write_mask,
  input  logic        of_read_ready,
  input  logic [23:0] of_read_count,
  input  logic [31:0] of_read_data,
  output logic        of_read_activate,
  output logic        of_read_strobe
);

  // state | meaning
  // IDLE  | waiting for a Wishbone request while the SDRAM is ready
  // WRITE | write burst: own a write half, push one word per acked stb
  // READ  | read burst: own a read block, pop one word per acked stb
  // FLUSH | cycle dropped: all FIFOs released, enables low for one cycle
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [21:0] addr_q, addr_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  wr_act_q, wr_act_d;
  logic        wr_stb_q, wr_stb_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [3:0]  wr_mask_q, wr_mask_d;
  logic        rd_act_q, rd_act_d;
  logic        rd_stb_q, rd_stb_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] rd_len_q, rd_len_d;
  logic        req;

  logic unused_adr_hi;
  assign unused_adr_hi = ^i_wbs_adr[31:22];

`ifdef SDRAM_WB_BRIDGE_TIMEOUT_EN
  logic [31:0] wait_q, wait_d;
  logic        starved;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  // A registered ack is still visible while stb is held; it must not start a second transfer.
  assign req = i_wbs_cyc && i_wbs_stb && !ack_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ack_d     = 1'b0;
    dat_d     = dat_q;
    wr_act_d  = wr_act_q;
    wr_stb_d  = 1'b0;
    wr_data_d = wr_data_q;
    wr_mask_d = wr_mask_q;
    rd_act_d  = rd_act_q;
    rd_stb_d  = 1'b0;
    cnt_d     = cnt_q;
    rd_len_d  = rd_len_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sdram_ready && i_wbs_cyc && i_wbs_stb) begin
          addr_d  = i_wbs_adr[21:0];
          state_d = i_wbs_we ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (!i_wbs_cyc) begin
          state_d  = ST_FLUSH;
          wr_act_d = 2'b00;
        end else if (wr_act_q == 2'b00) begin
          if (if_write_ready != 2'b00) begin
            wr_act_d = if_write_ready[0] ? 2'b01 : 2'b10;
            cnt_d    = '0;
          end
        end else if (cnt_q >= if_write_fifo_size) begin
          wr_act_d = 2'b00;
        end else if (req) begin
          wr_stb_d  = 1'b1;
          ack_d     = 1'b1;
          wr_data_d = i_wbs_dat;
          wr_mask_d = ~i_wbs_sel;
          cnt_d     = cnt_q + 24'd1;
        end
      end
      ST_READ: begin
        if (!i_wbs_cyc) begin
          state_d  = ST_FLUSH;
          rd_act_d = 1'b0;
        end else if (!rd_act_q) begin
          if (of_read_ready) begin
            rd_act_d = 1'b1;
            rd_len_d = of_read_count;
            cnt_d    = '0;
          end
        end else if (cnt_q >= rd_len_q) begin
          rd_act_d = 1'b0;
        end else if (req) begin
          dat_d    = of_read_data;
          ack_d    = 1'b1;
          rd_stb_d = 1'b1;
          cnt_d    = cnt_q + 24'd1;
        end
      end
      ST_FLUSH: begin
        wr_act_d = 2'b00;
        rd_act_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
`ifdef SDRAM_WB_BRIDGE_TIMEOUT_EN
    wait_d  = '0;
    starved = i_wbs_cyc &&
              (((state_q == ST_WRITE) && (wr_act_q == 2'b00) && (if_write_ready == 2'b00)) ||
               ((state_q == ST_READ) && !rd_act_q && !of_read_ready));
    if (starved && req) begin
      if (wait_q >= 32'(TIMEOUT_CYCLES - 1)) begin
        ack_d = 1'b1;
        if (state_q == ST_READ) dat_d = 32'hDEADBEEF;
      end else begin
        wait_d = wait_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      wr_act_q  <= 2'b00;
      wr_stb_q  <= 1'b0;
      wr_data_q <= '0;
      wr_mask_q <= '0;
      rd_act_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      cnt_q     <= '0;
      rd_len_q  <= '0;
`ifdef SDRAM_WB_BRIDGE_TIMEOUT_EN
      wait_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      wr_act_q  <= wr_act_d;
      wr_stb_q  <= wr_stb_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
      rd_act_q  <= rd_act_d;
      rd_stb_q  <= rd_stb_d;
      cnt_q     <= cnt_d;
      rd_len_q  <= rd_len_d;
`ifdef SDRAM_WB_BRIDGE_TIMEOUT_EN
      wait_q    <= wait_d;
`endif
    end
  end

  assign o_wbs_ack          = ack_q;
  assign o_wbs_dat          = dat_q;
  assign app_address        = addr_q;
  assign sdram_write_enable = (state_q == ST_WRITE);
  assign sdram_read_enable  = (state_q == ST_READ);
  assign if_write_activate  = wr_act_q;
  assign if_write_strobe    = wr_stb_q;
  assign if_write_data      = wr_data_q;
  assign if_write_mask      = wr_mask_q;
  assign of_read_activate   = rd_act_q;
  assign of_read_strobe     = rd_stb_q;

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Self-checking bench for sdram_wb_bridge with behavioural write/read ping-pong FIFO models.
// The timeout scenario is exercised when SDRAM_WB_BRIDGE_TIMEOUT_EN is defined.
module tb_sdram_wb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_wbs_cyc = 1'b0, i_wbs_stb = 1'b0, i_wbs_we = 1'b0;
  logic [3:0]  i_wbs_sel = 4'h0;
  logic [31:0] i_wbs_adr = '0, i_wbs_dat = '0;
  logic [31:0] o_wbs_dat;
  logic        o_wbs_ack;
  logic        sdram_ready = 1'b1;
  logic        sdram_write_enable, sdram_read_enable;
  logic [21:0] app_address;
  logic [1:0]  if_write_ready;
  logic [23:0] if_write_fifo_size = 24'd256;
  logic [1:0]  if_write_activate;
  logic        if_write_strobe;
  logic [31:0] if_write_data;
  logic [3:0]  if_write_mask;
  logic        of_read_ready;
  logic [23:0] of_read_count;
  logic [31:0] of_read_data;
  logic        of_read_activate, of_read_strobe;

  int total = 0;
  int bad = 0;

  sdram_wb_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .i_wbs_cyc(i_wbs_cyc), .i_wbs_stb(i_wbs_stb), .i_wbs_we(i_wbs_we),
    .i_wbs_sel(i_wbs_sel), .i_wbs_adr(i_wbs_adr), .i_wbs_dat(i_wbs_dat),
    .o_wbs_dat(o_wbs_dat), .o_wbs_ack(o_wbs_ack),
    .sdram_ready(sdram_ready),
    .sdram_write_enable(sdram_write_enable), .sdram_read_enable(sdram_read_enable),
    .app_address(app_address),
    .if_write_ready(if_write_ready), .if_write_fifo_size(if_write_fifo_size),
    .if_write_activate(if_write_activate), .if_write_strobe(if_write_strobe),
    .if_write_data(if_write_data), .if_write_mask(if_write_mask),
    .of_read_ready(of_read_ready), .of_read_count(of_read_count),
    .of_read_data(of_read_data), .of_read_activate(of_read_activate),
    .of_read_strobe(of_read_strobe)
  );

  always #5 clk = ~clk;

  // Write ppfifo model: a half is busy while owned, and becomes ready again 3 cycles after release.
  logic [1:0] mdl_ready;
  logic [1:0] prev_act;
  int         refill [2];
  logic       wr_ready_en = 1'b1;
  assign if_write_ready = wr_ready_en ? mdl_ready : 2'b00;

  always @(posedge clk) begin
    if (rst) begin
      mdl_ready <= 2'b11;
      prev_act  <= 2'b00;
      refill[0] <= 0;
      refill[1] <= 0;
    end else begin
      prev_act <= if_write_activate;
      for (int h = 0; h < 2; h++) begin
        if (if_write_activate[h]) mdl_ready[h] <= 1'b0;
        else if (prev_act[h]) refill[h] <= 3;
        else if (refill[h] != 0) begin
          refill[h] <= refill[h] - 1;
          if (refill[h] == 1) mdl_ready[h] <= 1'b1;
        end
      end
    end
  end

  // Read ppfifo model: blocks loaded by tasks, consumed word by word on strobe.
  logic [31:0] rd_mem [256];
  int          blk_len [16];
  int          blk_loaded = 0;
  int          rd_wr_idx = 0;
  int          blk_taken;
  int          rd_ptr;
  logic        prev_ract;
  assign of_read_ready = (blk_loaded != blk_taken) && !of_read_activate;
  assign of_read_count = 24'(blk_len[blk_taken[3:0]]);
  assign of_read_data  = of_read_activate ? rd_mem[rd_ptr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      blk_taken <= 0;
      rd_ptr    <= 0;
      prev_ract <= 1'b0;
    end else begin
      prev_ract <= of_read_activate;
      if (of_read_activate && !prev_ract) blk_taken <= blk_taken + 1;
      if (of_read_strobe && of_read_activate) rd_ptr <= rd_ptr + 1;
    end
  end

  // Capture of write-FIFO traffic and protocol violations.
  logic [31:0] cap_data [64];
  logic [3:0]  cap_mask [64];
  logic [1:0]  cap_act  [64];
  int          cap_cnt;
  int          rd_stb_cnt;
  int          viol = 0;

  always @(negedge clk) begin
    if (rst) begin
      cap_cnt    <= 0;
      rd_stb_cnt <= 0;
    end else begin
      if (if_write_strobe && cap_cnt < 64) begin
        cap_data[cap_cnt] <= if_write_data;
        cap_mask[cap_cnt] <= if_write_mask;
        cap_act[cap_cnt]  <= if_write_activate;
        cap_cnt <= cap_cnt + 1;
      end
      if (of_read_strobe) rd_stb_cnt <= rd_stb_cnt + 1;
      if (o_wbs_ack && !(i_wbs_cyc && i_wbs_stb)) viol <= viol + 1;
      if (if_write_strobe && if_write_activate == 2'b00) viol <= viol + 1;
      if (of_read_strobe && !of_read_activate) viol <= viol + 1;
      if (sdram_write_enable && sdram_read_enable) viol <= viol + 1;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    i_wbs_cyc = 1'b0;
    i_wbs_stb = 1'b0;
    wr_ready_en = 1'b1;
    blk_loaded = 0;
    rd_wr_idx = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_block(input int len);
    for (int i = 0; i < len; i++) begin
      rd_mem[rd_wr_idx] = $urandom;
      rd_wr_idx++;
    end
    blk_len[blk_loaded] = len;
    blk_loaded++;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          output bit ok);
    i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1; i_wbs_we = 1'b1;
    i_wbs_adr = adr; i_wbs_dat = dat; i_wbs_sel = sel;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (o_wbs_ack) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1 i_wbs_stb = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat, output bit ok);
    i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1; i_wbs_we = 1'b0;
    i_wbs_adr = adr; i_wbs_sel = 4'hF;
    ok = 1'b0;
    dat = '0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (o_wbs_ack) begin ok = 1'b1; dat = o_wbs_dat; break; end
    end
    @(posedge clk);
    #1 i_wbs_stb = 1'b0;
  endtask

  task automatic end_cycle();
    i_wbs_cyc = 1'b0;
    i_wbs_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1; i_wbs_we = 1'b1;
    i_wbs_adr = 32'h0012_3456;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({o_wbs_ack, o_wbs_dat, app_address, if_write_activate, of_read_activate} !== '0) begin
      bad++;
      $display("FAIL reset_bus ack=%b dat=%h adr=%h wact=%b ract=%b, all required 0",
               o_wbs_ack, o_wbs_dat, app_address, if_write_activate, of_read_activate);
    end
    total++;
    if ({if_write_strobe, of_read_strobe, if_write_data, if_write_mask,
         sdram_write_enable, sdram_read_enable} !== '0) begin
      bad++;
      $display("FAIL reset_fifo wstb=%b rstb=%b wdata=%h mask=%b wen=%b ren=%b, all required 0",
               if_write_strobe, of_read_strobe, if_write_data, if_write_mask,
               sdram_write_enable, sdram_read_enable);
    end
    do_reset();
    sdram_ready = 1'b0;
    i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1; i_wbs_we = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++;
    if ({sdram_write_enable, sdram_read_enable, o_wbs_ack} !== 3'b000) begin
      bad++;
      $display("FAIL not_ready_ignored wen=%b ren=%b ack=%b, required 000",
               sdram_write_enable, sdram_read_enable, o_wbs_ack);
    end
    sdram_ready = 1'b1;
    end_cycle();
  endtask

  task automatic test_write_basic();
    bit ok;
    logic [31:0] d [4];
    int n;
    do_reset();
    if_write_fifo_size = 24'd256;
    for (int k = 0; k < 4; k++) begin
      d[k] = $urandom;
      wb_write(32'h100, d[k], 4'b0011, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL wr_ack word %0d: no ack within 200 cycles", k); end
    end
    @(negedge clk);
    total++;
    if (app_address !== 22'h000100 || sdram_write_enable !== 1'b1) begin
      bad++;
      $display("FAIL wr_address adr=%h wen=%b, required 000100 and 1", app_address, sdram_write_enable);
    end
    total++;
    if (cap_cnt !== 4) begin bad++; $display("FAIL wr_strobe_count got %0d, required 4", cap_cnt); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (cap_data[k] !== d[k] || cap_mask[k] !== 4'b1100 || cap_act[k] !== 2'b01) begin
        bad++;
        $display("FAIL wr_word %0d data=%h mask=%b act=%b, required %h 1100 01",
                 k, cap_data[k], cap_mask[k], cap_act[k], d[k]);
      end
    end
    i_wbs_cyc = 1'b0;
    n = 0;
    while (if_write_activate != 2'b00 && n < 4) begin @(negedge clk); n++; end
    total++;
    if (if_write_activate !== 2'b00) begin
      bad++; $display("FAIL wr_release act=%b after cyc drop, required 00", if_write_activate);
    end
    repeat (2) @(negedge clk);
    total++;
    if ({sdram_write_enable, sdram_read_enable} !== 2'b00) begin
      bad++; $display("FAIL wr_flush_enables wen=%b ren=%b, required 00", sdram_write_enable, sdram_read_enable);
    end
    end_cycle();
  endtask

  task automatic test_read_block();
    bit ok;
    logic [31:0] r;
    int n;
    do_reset();
    load_block(8);
    for (int k = 0; k < 8; k++) begin
      wb_read(32'h0000_0200, r, ok);
      total++;
      if (!ok || r !== rd_mem[k]) begin
        bad++; $display("FAIL rd_word %0d ack=%b data=%h, required ack and %h", k, ok, r, rd_mem[k]);
      end
    end
    total++;
    if (rd_stb_cnt !== 8) begin bad++; $display("FAIL rd_strobe_count got %0d, required 8", rd_stb_cnt); end
    n = 0;
    while (of_read_activate && n < 4) begin @(negedge clk); n++; end
    total++;
    if (of_read_activate !== 1'b0 || sdram_read_enable !== 1'b1) begin
      bad++; $display("FAIL rd_release act=%b ren=%b, required 0 and 1", of_read_activate, sdram_read_enable);
    end
    end_cycle();
  endtask

  task automatic test_write_halves();
    bit ok;
    logic [31:0] d [3];
    logic [1:0] exp_act;
    do_reset();
    if_write_fifo_size = 24'd2;
    for (int k = 0; k < 3; k++) begin
      d[k] = $urandom;
      wb_write(32'h40 + 32'(k), d[k], 4'b1111, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL half_ack word %0d: no ack within 200 cycles", k); end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_act = (k < 2) ? 2'b01 : 2'b10;
      total++;
      if (cap_data[k] !== d[k] || cap_act[k] !== exp_act) begin
        bad++;
        $display("FAIL half_word %0d data=%h act=%b, required %h %b", k, cap_data[k], cap_act[k], d[k], exp_act);
      end
    end
    end_cycle();
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    do_reset();
    if_write_fifo_size = 24'd256;
    for (int k = 0; k < 2; k++) wb_write(32'h80, $urandom, 4'hF, ok);
    i_wbs_stb = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({if_write_activate, sdram_write_enable, sdram_read_enable, o_wbs_ack, if_write_strobe} !== '0
        || app_address !== 22'h0) begin
      bad++;
      $display("FAIL midrst act=%b wen=%b ren=%b ack=%b stb=%b adr=%h, all required 0",
               if_write_activate, sdram_write_enable, sdram_read_enable, o_wbs_ack, if_write_strobe, app_address);
    end
    #1 rst = 1'b0;
    i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0;
    @(negedge clk);
    total++;
    if ({sdram_write_enable, sdram_read_enable} !== 2'b00) begin
      bad++; $display("FAIL midrst_idle wen=%b ren=%b, required 00", sdram_write_enable, sdram_read_enable);
    end
    end_cycle();
  endtask

  task automatic test_random_traffic();
    bit ok;
    int size, n, nblk, words;
    logic [31:0] d [16];
    logic [3:0]  s [16];
    logic [31:0] r;
    logic [1:0]  exp_act;
    do_reset();
    size = $urandom_range(1, 4);
    n = $urandom_range(5, 12);
    if_write_fifo_size = 24'(size);
    for (int k = 0; k < n; k++) begin
      d[k] = $urandom;
      s[k] = 4'($urandom);
      wb_write($urandom, d[k], s[k], ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rnd_wr_ack word %0d: no ack within 200 cycles", k); end
    end
    @(negedge clk);
    total++;
    if (cap_cnt !== n) begin bad++; $display("FAIL rnd_wr_count got %0d, required %0d", cap_cnt, n); end
    for (int k = 0; k < n; k++) begin
      exp_act = ((k / size) % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if (cap_data[k] !== d[k] || cap_mask[k] !== ~s[k] || cap_act[k] !== exp_act) begin
        bad++;
        $display("FAIL rnd_wr_word %0d size=%0d data=%h mask=%b act=%b, required %h %b %b",
                 k, size, cap_data[k], cap_mask[k], cap_act[k], d[k], ~s[k], exp_act);
      end
    end
    end_cycle();
    do_reset();
    nblk = $urandom_range(2, 3);
    words = 0;
    for (int b = 0; b < nblk; b++) begin
      n = $urandom_range(1, 5);
      load_block(n);
      words += n;
    end
    for (int k = 0; k < words; k++) begin
      wb_read($urandom, r, ok);
      total++;
      if (!ok || r !== rd_mem[k]) begin
        bad++; $display("FAIL rnd_rd_word %0d ack=%b data=%h, required ack and %h", k, ok, r, rd_mem[k]);
      end
    end
    total++;
    if (rd_stb_cnt !== words) begin
      bad++; $display("FAIL rnd_rd_strobes got %0d, required %0d", rd_stb_cnt, words);
    end
    end_cycle();
  endtask

  task automatic test_fifo_wait();
    int n;
    bit ok;
    logic [31:0] r;
    do_reset();
    if_write_fifo_size = 24'd256;
    wr_ready_en = 1'b0;
    i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1; i_wbs_we = 1'b1;
    i_wbs_dat = 32'h1234_5678; i_wbs_sel = 4'hF;
    @(posedge clk);
    n = 0;
    ok = 1'b0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (o_wbs_ack) begin ok = 1'b1; break; end
    end
`ifdef SDRAM_WB_BRIDGE_TIMEOUT_EN
    total++;
    if (!ok || n !== 16) begin
      bad++; $display("FAIL timeout_wr_latency ack=%b cycles=%0d, required ack after 16", ok, n);
    end
    total++;
    if (cap_cnt !== 0) begin bad++; $display("FAIL timeout_wr_dropped strobes=%0d, required 0", cap_cnt); end
    end_cycle();
    do_reset();
    wb_read(32'h10, r, ok);
    total++;
    if (!ok || r !== 32'hDEADBEEF) begin
      bad++; $display("FAIL timeout_rd_data ack=%b data=%h, required ack and deadbeef", ok, r);
    end
`else
    total++;
    if (ok) begin bad++; $display("FAIL wait_no_ack ack seen after %0d cycles with no FIFO, required none", n); end
    wr_ready_en = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_wbs_ack) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1 i_wbs_stb = 1'b0;
    total++;
    if (!ok || cap_cnt !== 1 || cap_data[0] !== 32'h1234_5678) begin
      bad++;
      $display("FAIL wait_then_write ack=%b strobes=%0d data=%h, required ack 1 12345678", ok, cap_cnt, cap_data[0]);
    end
    r = '0;
`endif
    end_cycle();
  endtask

  task automatic test_protocol_invariants();
    total++;
    if (viol !== 0) begin
      bad++; $display("FAIL protocol_invariants violations=%0d, required 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_block();
    test_write_halves();
    test_reset_mid_burst();
    for (int i = 0; i < 4; i++) test_random_traffic();
    test_fifo_wait();
    test_protocol_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_wb_bridge.md
SDRAM_WB_BRIDGE -- requirements
Module: sdram_wb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the FIFO-wait limit in clk cycles (used only when the Configuration macro is defined).
REQ-002 SHALL have port clk  input  1  single clock for all logic, also the write-side clock of the write ppfifo and the read-side clock of the read ppfifo.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port i_wbs_cyc  input  1  Wishbone bus cycle.
REQ-005 SHALL have port i_wbs_stb  input  1  Wishbone strobe.
REQ-006 SHALL have port i_wbs_we  input  1  Wishbone write enable (1 = write).
REQ-007 SHALL have port i_wbs_sel  input  4  Wishbone byte selects.
REQ-008 SHALL have port i_wbs_adr  input  32  Wishbone word address; bits [21:0] are used.
REQ-009 SHALL have port i_wbs_dat  input  32  Wishbone write data.
REQ-010 SHALL have port o_wbs_dat  output  32  Wishbone read data.
REQ-011 SHALL have port o_wbs_ack  output  1  Wishbone acknowledge, single-cycle pulse.
REQ-012 SHALL have port sdram_ready  input  1  SDRAM controller initialised.
REQ-013 SHALL have port sdram_write_enable  output  1  request a write burst from the controller.
REQ-014 SHALL have port sdram_read_enable  output  1  request a read burst from the controller.
REQ-015 SHALL have port app_address  output  22  burst start word address.
REQ-016 SHALL have port if_write_ready  input  2  write-ppfifo half ready flags.
REQ-017 SHALL have port if_write_fifo_size  input  24  write-ppfifo half capacity in words.
REQ-018 SHALL have port if_write_activate  output  2  write-ppfifo half ownership.
REQ-019 SHALL have port if_write_strobe  output  1  write one word into the write ppfifo.
REQ-020 SHALL have port if_write_data  output  32  word written into the write ppfifo.
REQ-021 SHALL have port if_write_mask  output  4  DQM for that word, 1 = byte masked.
REQ-022 SHALL have port of_read_ready  input  1  a read-ppfifo block is available.
REQ-023 SHALL have port of_read_count  input  24  number of words in that block.
REQ-024 SHALL have port of_read_data  input  32  head word of the block; valid while activated.
REQ-025 SHALL have port of_read_activate  output  1  read-ppfifo block ownership.
REQ-026 SHALL have port of_read_strobe  output  1  pop one word from the read ppfifo.

Function
REQ-027 SHALL implement a state machine with states IDLE, WRITE, READ, FLUSH; requests are accepted only in IDLE with sdram_ready=1.
REQ-028 IDLE, on cyc&stb: SHALL latch app_address<=i_wbs_adr[21:0]; SHALL go to WRITE if i_wbs_we=1, else to READ; SHALL hold sdram_write_enable / sdram_read_enable high for the whole of WRITE / READ respectively.
REQ-029 WRITE acquire: when if_write_activate==0 and if_write_ready!=0, SHALL set activate bit0 if ready[0]=1, else bit1, and clear the word counter.
REQ-030 WRITE transfer: per stb while activated and count<if_write_fifo_size: SHALL pulse if_write_strobe and o_wbs_ack in the same cycle, with if_write_data=i_wbs_dat and if_write_mask=~i_wbs_sel; SHALL add at most one word per cycle; latency from stb to ack is 1 cycle once activated.
REQ-031 WRITE full: when count==if_write_fifo_size, SHALL clear activate and then reacquire the other half per REQ-029 before the next ack (no acks while no half is owned).
REQ-032 READ acquire: when of_read_ready=1 and not activated, SHALL set of_read_activate, latch of_read_count, and clear the counter.
REQ-033 READ transfer: per stb while activated and count<latched count: SHALL register o_wbs_dat<=of_read_data, pulse o_wbs_ack and of_read_strobe in the same cycle; when the block is exhausted (count==latched) SHALL release and reacquire.
REQ-034 i_wbs_cyc falling in WRITE/READ: SHALL clear all activate bits and deassert both enables in FLUSH (1 cycle), then return to IDLE; a partially filled write half is released with its count intact.
REQ-035 SHALL never assert o_wbs_ack without cyc&stb, never assert strobe without activate, never assert both enables at once.

Reset
REQ-036 On rst=1 at a clk edge: state IDLE; o_wbs_ack, o_wbs_dat, app_address, all activates, strobes, masks, data, and both enables SHALL be 0 on the next cycle, including when rst arrives mid-burst.

Configuration
REQ-037 Macro SDRAM_WB_BRIDGE_TIMEOUT_EN defined: in WRITE/READ, a pending stb that cannot acquire a FIFO for TIMEOUT_CYCLES consecutive cycles SHALL be acked (write data dropped, read data 0xDEADBEEF), and the wait counter then restarts; undefined: the block SHALL wait indefinitely and no timeout counter SHALL exist.

Verification
REQ-038 Write 4 words at adr 0x100, sel 4'b0011, size 256, ready=2'b11 -> activate=2'b01, app_address=0x000100, 4 strobes, mask=4'b1100, release after cyc drops.
REQ-039 Read: of_read_count=8, 8 stb -> 8 acks, o_wbs_dat matches of_read_data, 8 of_read_strobe, activate falls after the 8th.
REQ-040 Size=2, 3 writes -> release bit0 after 2, acquire bit1, 3rd word into bit1.
REQ-041 rst pulse after 2nd of 4 writes -> activate=0, enables=0 next cycle, state IDLE.
REQ-042 With macro and TIMEOUT_CYCLES=16, ready=0 -> ack 16 cycles after stb, no if_write_strobe.
